gem_cluster_lut_scheduler: RTL
==============================

# gem_cluster_lut_scheduler

Time-multiplexes the up-to-8 GEM clusters that arrive each bunch crossing onto NLANES shared pad/roll-to-CSC translation lanes: the dual-port LUT datapaths that map GEM roll/pad to CSC wiregroup and halfstrip ranges. It captures a BX's clusters on a strobe, issues only the valid ones lowest-index-first, and collects the lane results into per-cluster slots. It then publishes one aligned result vector per BX toward the GEM-CSC matching logic. It sits between the GEM cluster receiver and the translator lanes.

## Interface
- NCLUSTERS, 8: clusters per BX.
- NLANES, 2: translator lanes available per clock.
- LUT_LATENCY, 1: clocks from lane request to lane result (1..3).
- clock  in  1  fabric clock, several cycles per BX.
- reset_n  in  1  asynchronous, active-low reset.
- bx_strobe  in  1  one-cycle pulse; in_* valid in the same cycle.
- in_vpf  in  NCLUSTERS  cluster valid flags.
- in_roll  in  3*NCLUSTERS  roll 0-7 per cluster.
- in_pad  in  8*NCLUSTERS  pad 0-191 per cluster.
- in_size  in  3*NCLUSTERS  size 0-7 (0 = one pad).
- lane_vpf  out  NLANES  registered lane request valid.
- lane_roll / lane_pad / lane_size  out  3/8/3*NLANES  registered request fields.
- res_wire_lo / res_wire_hi  in  7*NLANES  lane wiregroup window.
- res_hs_lo / res_hs_hi  in  8*NLANES  lane halfstrip window; 224 = invalid.
- res_me1a  in  NLANES  lane result is ME1a.
- out_valid  out  1  one-cycle pulse; out_* stable until next pulse.
- out_vpf  out  NCLUSTERS  slot holds a translated cluster.
- out_wire_lo / out_wire_hi  out  7*NCLUSTERS  per-slot wiregroup window.
- out_hs_lo / out_hs_hi  out  8*NCLUSTERS  per-slot halfstrip window.
- out_me1a  out  NCLUSTERS  per-slot ME1a flag.
- busy  out  1  state != IDLE.
- overflow  out  1  one-cycle pulse when a BX is truncated.
- drop_count  out  8  saturating count of dropped clusters.

## Operation
- States are IDLE, ISSUE, DRAIN and DONE.
- **IDLE**
  - On bx_strobe: latch the in_* fields, set pending = in_vpf, clear slot flags, go to ISSUE.
- **ISSUE**
  - Each clock, take the lowest-index set bits of pending, up to NLANES of them.
  - Drive them onto lanes 0..k-1 in ascending index order; lanes k..NLANES-1 get lane_vpf = 0.
  - Clear those bits from pending.
  - Push each lane's slot index into a LUT_LATENCY-deep tag pipeline.
  - When pending becomes empty after this clock's issue, go to DRAIN with drain counter = LUT_LATENCY. With zero valid clusters, this happens on the first ISSUE clock and nothing is issued.
- **Result capture** (every state): when a tag pipeline stage emerges valid, write res_* of that lane into its slot and set the slot's captured bit.
- **DRAIN**: decrement the counter each clock; at zero go to DONE.
- **DONE**
  - Register the slots onto out_*; out_vpf = captured bits.
  - Pulse out_valid and go to IDLE.
  - If bx_strobe arrives in the same clock, load the new BX and go to ISSUE instead.
- **bx_strobe in ISSUE or DRAIN (truncation)**
  - Publish the current slots immediately, with out_vpf = captured bits only.
  - Discard in-flight tags.
  - Pulse overflow.
  - drop_count += number of valid clusters not captured, saturating at 255.
  - Load the new BX and go to ISSUE.
- **Field ordering**: cluster i occupies bits [W*i +: W] of each packed bus.
- **Lane results** are taken as-is; the scheduler does no window arithmetic.

## Timing
- bx_strobe is sampled at edge E0.
- With n valid clusters:
  - lane requests appear after edges E1..E⌈n/NLANES⌉;
  - results are sampled LUT_LATENCY edges later;
  - out_valid is high after edge E(max(⌈n/NLANES⌉,1)+LUT_LATENCY+1).
- Example, n=8, NLANES=2, LUT_LATENCY=1: issues after E1..E4, captures E2..E5, out_valid after E6.
- A BX strobe spacing of at least that latency+1 clocks avoids truncation.
- Reset state:
  - all outputs 0, including out_hs_* (not 224);
  - state IDLE, pending/tags/slots cleared.
- A reset asserted mid-BX abandons it with no out_valid pulse.

## Configuration
- GEM_SCHED_STATS_EN
  - Defined: drop_count is implemented as specified. It is cleared only by reset.
  - Undefined: drop_count is tied to 0 and its logic is removed. overflow and truncation behaviour are unchanged.

## Structure
- Shared package gem_sched_pkg holds:
  - WIREBITS=7, STRIPBITS=8, ROLLBITS=3, PADBITS=8, SIZEBITS=3;
  - HS_INVALID=8'd224;
  - the state enum encoding.
- One sub-module, gem_sched_pick: combinational picker returning up to NLANES lowest set indices of a NCLUSTERS-bit mask, plus a per-lane valid.

## Test plan
- **Eight valid clusters, pads 0..7, roll 7, lane model returns hs = 128+pad.** Expect out_valid after E6, out_vpf = 8'hFF, slot i out_hs_lo = 128+i, out_me1a all 1.
- **in_vpf = 8'b1010_0100.** Expect lanes to issue slots {2,5} then {7}; out_valid after E4; out_vpf = 8'b1010_0100; the other slots read 0.
- **in_vpf = 0.** Expect no lane_vpf; out_valid after E3 with out_vpf = 0.
- **Second bx_strobe at E2 of an 8-cluster BX.** Expect:
  - overflow pulses;
  - first out_vpf = 8'b0000_0011;
  - drop_count = 6 (0 when GEM_SCHED_STATS_EN is undefined);
  - the new BX completes normally.
- **LUT_LATENCY = 3 with a randomized lane model.** Every result must land in the slot of its issued index; out_valid arrives after E(⌈n/2⌉+4).
- **reset_n asserted at E3 of a BX.** Outputs go to 0 asynchronously and there is no out_valid; a strobe after release is processed normally.

Source files
------------

// File: rtl/gem_sched_pkg.sv
// Shared widths, sentinel values and FSM encoding for the GEM cluster LUT scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gem_sched_pkg;

  localparam int WIREBITS  = 7;
  localparam int STRIPBITS = 8;
  localparam int ROLLBITS  = 3;
  localparam int PADBITS   = 8;
  localparam int SIZEBITS  = 3;

  // Halfstrip value a lane returns when the pad has no CSC overlap.
  localparam logic [STRIPBITS-1:0] HS_INVALID = 8'd224;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_t;

  // One translated cluster as returned by a lane.
  typedef struct packed {
    logic [WIREBITS-1:0]  wire_lo;
    logic [WIREBITS-1:0]  wire_hi;
    logic [STRIPBITS-1:0] hs_lo;
    logic [STRIPBITS-1:0] hs_hi;
    logic                 me1a;
  } slot_t;

endpackage

// File: rtl/gem_sched_pick.sv
// Picks up to NLANES lowest-index set bits of a mask, lane 0 getting the lowest.
// Latency: combinational.
// Backpressure: none; caller clears pick_mask bits from its pending mask.
module gem_sched_pick #(
  parameter int NCLUSTERS = 8,
  parameter int NLANES    = 2,
  parameter int IDXW      = $clog2(NCLUSTERS)
) (
  input  logic [NCLUSTERS-1:0]   mask,
  output logic [NLANES-1:0]      pick_vld,
  output logic [NLANES*IDXW-1:0] pick_idx,
  output logic [NCLUSTERS-1:0]   pick_mask
);

  logic [NCLUSTERS-1:0] remain;
  logic                 found;

  // Repeated lowest-set-bit search, removing each hit before the next lane looks.
  always_comb begin
    remain    = mask;
    found     = 1'b0;
    pick_vld  = '0;
    pick_idx  = '0;
    pick_mask = '0;
    for (int l = 0; l < NLANES; l++) begin
      found = 1'b0;
      for (int i = 0; i < NCLUSTERS; i++) begin
        if (!found && remain[i]) begin
          found                       = 1'b1;
          pick_vld[l]                 = 1'b1;
          pick_idx[l*IDXW +: IDXW]    = IDXW'(i);
          remain[i]                   = 1'b0;
          pick_mask[i]                = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gem_cluster_lut_scheduler.sv
// Time-multiplexes a BX's GEM clusters onto NLANES LUT lanes and publishes one aligned result vector per BX.
// Latency: out_valid after max(ceil(n/NLANES),1)+LUT_LATENCY+1 clocks from bx_strobe; GEM_SCHED_STATS_EN enables drop_count.
// Backpressure: none; a strobe while a BX is still issuing/draining truncates it (partial publish + overflow pulse).
module gem_cluster_lut_scheduler
  import gem_sched_pkg::*;
#(
  parameter int NCLUSTERS   = 8,
  parameter int NLANES      = 2,
  parameter int LUT_LATENCY = 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           bx_strobe,
  input  logic [NCLUSTERS-1:0]           in_vpf,
  input  logic [ROLLBITS*NCLUSTERS-1:0]  in_roll,
  input  logic [PADBITS*NCLUSTERS-1:0]   in_pad,
  input  logic [SIZEBITS*NCLUSTERS-1:0]  in_size,
  output logic [NLANES-1:0]              lane_vpf,
  output logic [ROLLBITS*NLANES-1:0]     lane_roll,
  output logic [PADBITS*NLANES-1:0]      lane_pad,
  output logic [SIZEBITS*NLANES-1:0]     lane_size,
  input  logic [WIREBITS*NLANES-1:0]     res_wire_lo,
  input  logic [WIREBITS*NLANES-1:0]     res_wire_hi,
  input  logic [STRIPBITS*NLANES-1:0]    res_hs_lo,
  input  logic [STRIPBITS*NLANES-1:0]    res_hs_hi,
  input  logic [NLANES-1:0]              res_me1a,
  output logic                           out_valid,
  output logic [NCLUSTERS-1:0]           out_vpf,
  output logic [WIREBITS*NCLUSTERS-1:0]  out_wire_lo,
  output logic [WIREBITS*NCLUSTERS-1:0]  out_wire_hi,
  output logic [STRIPBITS*NCLUSTERS-1:0] out_hs_lo,
  output logic [STRIPBITS*NCLUSTERS-1:0] out_hs_hi,
  output logic [NCLUSTERS-1:0]           out_me1a,
  output logic                           busy,
  output logic                           overflow,
  output logic [7:0]                     drop_count
);

  localparam int IDXW = $clog2(NCLUSTERS);

  sched_state_t                  state;
  logic [NCLUSTERS-1:0]          pending;
  logic [NCLUSTERS-1:0]          captured;
  logic [NCLUSTERS-1:0]          capt_nx;
  logic [ROLLBITS*NCLUSTERS-1:0] roll_q;
  logic [PADBITS*NCLUSTERS-1:0]  pad_q;
  logic [SIZEBITS*NCLUSTERS-1:0] size_q;
  slot_t [NCLUSTERS-1:0]         slot_q;
  slot_t [NCLUSTERS-1:0]         slot_nx;
  logic [1:0]                    drain_cnt;

  // Slot index travelling alongside each lane request until its result returns.
  logic [NLANES-1:0]             tag_vld [LUT_LATENCY];
  logic [NLANES*IDXW-1:0]        tag_idx [LUT_LATENCY];

  logic [NLANES-1:0]             pick_vld;
  logic [NLANES*IDXW-1:0]        pick_idx;
  logic [NCLUSTERS-1:0]          pick_mask;
  logic [NLANES-1:0]             iss_vld;
  logic                          truncate;
  logic                          publish;

  logic [ROLLBITS*NLANES-1:0]     lane_roll_nx;
  logic [PADBITS*NLANES-1:0]      lane_pad_nx;
  logic [SIZEBITS*NLANES-1:0]     lane_size_nx;
  logic [WIREBITS*NCLUSTERS-1:0]  pub_wire_lo;
  logic [WIREBITS*NCLUSTERS-1:0]  pub_wire_hi;
  logic [STRIPBITS*NCLUSTERS-1:0] pub_hs_lo;
  logic [STRIPBITS*NCLUSTERS-1:0] pub_hs_hi;
  logic [NCLUSTERS-1:0]           pub_me1a;

  gem_sched_pick #(
    .NCLUSTERS (NCLUSTERS),
    .NLANES    (NLANES),
    .IDXW      (IDXW)
  ) u_pick (
    .mask      (pending),
    .pick_vld  (pick_vld),
    .pick_idx  (pick_idx),
    .pick_mask (pick_mask)
  );

  // A strobe always wins: no issue happens in the clock that loads a new BX.
  assign iss_vld  = (state == ST_ISSUE && !bx_strobe) ? pick_vld : '0;
  assign truncate = bx_strobe && (state == ST_ISSUE || state == ST_DRAIN);
  assign publish  = truncate || (state == ST_DONE);
  assign busy     = (state != ST_IDLE);

  // Slot contents including results landing this clock, so a truncating publish sees them.
  always_comb begin
    slot_nx = slot_q;
    capt_nx = captured;
    for (int l = 0; l < NLANES; l++) begin
      if (tag_vld[LUT_LATENCY-1][l]) begin
        slot_nx[tag_idx[LUT_LATENCY-1][l*IDXW +: IDXW]] = '{
          wire_lo: res_wire_lo[l*WIREBITS +: WIREBITS],
          wire_hi: res_wire_hi[l*WIREBITS +: WIREBITS],
          hs_lo:   res_hs_lo[l*STRIPBITS +: STRIPBITS],
          hs_hi:   res_hs_hi[l*STRIPBITS +: STRIPBITS],
          me1a:    res_me1a[l]
        };
        capt_nx[tag_idx[LUT_LATENCY-1][l*IDXW +: IDXW]] = 1'b1;
      end
    end
  end

  // Gather the picked clusters' fields onto their lanes; idle lanes carry zeros.
  always_comb begin
    lane_roll_nx = '0;
    lane_pad_nx  = '0;
    lane_size_nx = '0;
    for (int l = 0; l < NLANES; l++) begin
      if (iss_vld[l]) begin
        lane_roll_nx[l*ROLLBITS +: ROLLBITS] = roll_q[pick_idx[l*IDXW +: IDXW]*ROLLBITS +: ROLLBITS];
        lane_pad_nx[l*PADBITS +: PADBITS]    = pad_q[pick_idx[l*IDXW +: IDXW]*PADBITS +: PADBITS];
        lane_size_nx[l*SIZEBITS +: SIZEBITS] = size_q[pick_idx[l*IDXW +: IDXW]*SIZEBITS +: SIZEBITS];
      end
    end
  end

  // Flatten slots into the packed output buses, cluster i at [W*i +: W].
  always_comb begin
    pub_wire_lo = '0;
    pub_wire_hi = '0;
    pub_hs_lo   = '0;
    pub_hs_hi   = '0;
    pub_me1a    = '0;
    for (int i = 0; i < NCLUSTERS; i++) begin
      pub_wire_lo[i*WIREBITS +: WIREBITS]  = slot_nx[i].wire_lo;
      pub_wire_hi[i*WIREBITS +: WIREBITS]  = slot_nx[i].wire_hi;
      pub_hs_lo[i*STRIPBITS +: STRIPBITS]  = slot_nx[i].hs_lo;
      pub_hs_hi[i*STRIPBITS +: STRIPBITS]  = slot_nx[i].hs_hi;
      pub_me1a[i]                          = slot_nx[i].me1a;
    end
  end

  // Scheduler FSM, lane request registers, tag pipeline, slot store and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pending     <= '0;
      captured    <= '0;
      roll_q      <= '0;
      pad_q       <= '0;
      size_q      <= '0;
      slot_q      <= '0;
      drain_cnt   <= '0;
      lane_vpf    <= '0;
      lane_roll   <= '0;
      lane_pad    <= '0;
      lane_size   <= '0;
      out_valid   <= 1'b0;
      out_vpf     <= '0;
      out_wire_lo <= '0;
      out_wire_hi <= '0;
      out_hs_lo   <= '0;
      out_hs_hi   <= '0;
      out_me1a    <= '0;
      overflow    <= 1'b0;
      for (int k = 0; k < LUT_LATENCY; k++) begin
        tag_vld[k] <= '0;
        tag_idx[k] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      overflow  <= truncate;

      tag_vld[0] <= iss_vld;
      tag_idx[0] <= pick_idx;
      for (int k = 1; k < LUT_LATENCY; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end

      slot_q    <= slot_nx;
      captured  <= capt_nx;
      lane_vpf  <= iss_vld;
      lane_roll <= lane_roll_nx;
      lane_pad  <= lane_pad_nx;
      lane_size <= lane_size_nx;

      if (publish) begin
        out_valid   <= 1'b1;
        out_vpf     <= capt_nx;
        out_wire_lo <= pub_wire_lo;
        out_wire_hi <= pub_wire_hi;
        out_hs_lo   <= pub_hs_lo;
        out_hs_hi   <= pub_hs_hi;
        out_me1a    <= pub_me1a;
      end

      if (bx_strobe) begin
        // New BX: anything still in flight belongs to the abandoned one.
        pending  <= in_vpf;
        roll_q   <= in_roll;
        pad_q    <= in_pad;
        size_q   <= in_size;
        slot_q   <= '0;
        captured <= '0;
        state    <= ST_ISSUE;
        for (int k = 0; k < LUT_LATENCY; k++) begin
          tag_vld[k] <= '0;
        end
      end else begin
        case (state)
          ST_ISSUE: begin
            pending <= pending & ~pick_mask;
            if ((pending & ~pick_mask) == '0) begin
              state     <= ST_DRAIN;
              drain_cnt <= 2'(LUT_LATENCY);
            end
          end
          ST_DRAIN: begin
            if (drain_cnt <= 2'd1) begin
              state <= ST_DONE;
            end else begin
              drain_cnt <= drain_cnt - 2'd1;
            end
          end
          ST_DONE:  state <= ST_IDLE;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef GEM_SCHED_STATS_EN
  logic [NCLUSTERS-1:0] vld_q;
  logic [8:0]           drop_sum;

  assign drop_sum = {1'b0, drop_count} + 9'($countones(vld_q & ~capt_nx));

  // Saturating count of clusters lost to truncation; only reset clears it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q      <= '0;
      drop_count <= '0;
    end else begin
      if (truncate) begin
        drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
      if (bx_strobe) begin
        vld_q <= in_vpf;
      end
    end
  end
`else
  assign drop_count = 8'd0;
`endif

endmodule
